// File: rtl/mdio_slave_regfile_pkg.sv
// mdio_pkg: frame FSM states, ST/OP encodings and field widths shared by the MDIO slave.
package mdio_pkg;
  typedef enum logic [2:0] {PREAMBLE, START, HDR, TA0, TA1, DATA, ABORT} state_t;
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;
  localparam logic [1:0] OP_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_C22_READ = 2'b10;
  localparam logic [1:0] OP_C45_READ_INC = 2'b10;
  localparam logic [1:0] OP_C45_READ = 2'b11;
  localparam int ADDR_BITS = 5;
  localparam int HDR_BITS = 12;
  localparam int DATA_BITS = 16;
endpackage

// File: rtl/mdio_slave_regfile_if.sv
// mdio_slave_regfile_if: split MDIO pad plus committed-write notification towards the PHY core.
interface mdio_slave_regfile_if;
  import mdio_pkg::*;
  logic mdio_in;
  logic mdio_out;
  logic mdio_oe;
  logic wr_strobe;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  modport slave (input mdio_in, output mdio_out, mdio_oe, wr_strobe, wr_addr, wr_data);
  modport master (output mdio_in, input mdio_out, mdio_oe, wr_strobe, wr_addr, wr_data);
endinterface

// File: rtl/mdio_slave_regfile_regfile.sv
// mdio_regfile: register storage, read-only muxing, write qualification and write strobe.
module mdio_regfile
  import mdio_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter logic [31:0] RO_MASK = 32'h0000_0006
) (
  input  logic mdc,
  input  logic reset,
  input  logic [ADDR_BITS-1:0] rd_idx,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic wr_req,
  input  logic [ADDR_BITS-1:0] wr_idx,
  input  logic [DATA_BITS-1:0] wr_val,
  input  logic [NUM_REGS*16-1:0] ro_data,
  output logic [NUM_REGS*16-1:0] reg_q,
  output logic wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data
);
  localparam logic [31:0] IMPL = NUM_REGS >= 32 ? 32'hFFFF_FFFF : (32'd1 << NUM_REGS) - 32'd1;
  localparam logic [31:0] WR_MASK = IMPL & ~RO_MASK;
  logic [DATA_BITS-1:0] view [32];
  logic wr_ok;
  logic unused_ro;
  assign unused_ro = ^ro_data;
  assign wr_ok = wr_req && WR_MASK[wr_idx];
  assign rd_data = view[rd_idx];
  // all 32 addresses get a view entry so unimplemented ones read back as zero
  for (genvar g = 0; g < 32; g++) begin : g_reg
    if (g >= NUM_REGS) begin : g_none
      assign view[g] = '0;
    end else if (RO_MASK[g]) begin : g_ro
      assign view[g] = ro_data[g*16 +: 16];
      assign reg_q[g*16 +: 16] = '0;
    end else begin : g_rw
      logic [DATA_BITS-1:0] r;
      always_ff @(posedge mdc or negedge reset)
        if (!reset) r <= '0;
        else if (wr_ok && wr_idx == 5'(g)) r <= wr_val;
      assign view[g] = r;
      assign reg_q[g*16 +: 16] = r;
    end
  end
  always_ff @(posedge mdc or negedge reset)
    if (!reset) begin
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_strobe <= wr_ok;
      if (wr_ok) begin
        wr_addr <= wr_idx;
        wr_data <= wr_val;
      end
    end
endmodule

// File: rtl/mdio_slave_regfile.sv
// mdio_slave_regfile: MDIO PHY-side slave decoding Clause 22 frames into a parametrised register file.
// Define MDIO_SLAVE_CLAUSE45_EN to also decode Clause 45 (ST=00) frames addressed to MMD_DEVAD.
module mdio_slave_regfile
  import mdio_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter logic [31:0] RO_MASK = 32'h0000_0006,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter logic [4:0] MMD_DEVAD = 5'd1
) (
  input  logic mdc,
  input  logic reset,
  input  logic [4:0] phy_address,
  input  logic [NUM_REGS*16-1:0] ro_data,
  output logic [NUM_REGS*16-1:0] reg_q,
  mdio_slave_regfile_if.slave mdio
);
  localparam logic [5:0] PRE = 6'(PREAMBLE_LEN);
  state_t state, state_d;
  logic [5:0] cnt, cnt_d;
  logic [HDR_BITS-1:0] hdr, hdr_d;
  logic [DATA_BITS-1:0] sh, sh_d, rd_data, wr_val;
  logic [ADDR_BITS-1:0] idx;
  logic oe, oe_d, out, out_d, adr, adr_d, wr_req, is_rd, last;
  assign is_rd = hdr[11];
  assign last = cnt == 6'(DATA_BITS - 1);
  assign wr_val = {sh[14:0], mdio.mdio_in};
  assign mdio.mdio_oe = oe;
  assign mdio.mdio_out = out;
`ifdef MDIO_SLAVE_CLAUSE45_EN
  logic c45, c45_d;
  logic [15:0] mmd_addr, mmd_addr_d;
  assign idx = c45 ? mmd_addr[4:0] : hdr[4:0];
`else
  assign idx = hdr[4:0];
`endif
  always_ff @(posedge mdc or negedge reset)
    if (!reset) begin
      state <= PREAMBLE;
      cnt <= '0;
      hdr <= '0;
      sh <= '0;
      oe <= 1'b0;
      out <= 1'b1;
      adr <= 1'b0;
`ifdef MDIO_SLAVE_CLAUSE45_EN
      c45 <= 1'b0;
      mmd_addr <= '0;
`endif
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      hdr <= hdr_d;
      sh <= sh_d;
      oe <= oe_d;
      out <= out_d;
      adr <= adr_d;
`ifdef MDIO_SLAVE_CLAUSE45_EN
      c45 <= c45_d;
      mmd_addr <= mmd_addr_d;
`endif
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    hdr_d = hdr;
    sh_d = sh;
    oe_d = oe;
    out_d = out;
    adr_d = adr;
    wr_req = 1'b0;
`ifdef MDIO_SLAVE_CLAUSE45_EN
    c45_d = c45;
    mmd_addr_d = mmd_addr;
`endif
    case (state)
      PREAMBLE: begin
        cnt_d = mdio.mdio_in ? (cnt == PRE ? cnt : cnt + 6'd1) : '0;
        state_d = (!mdio.mdio_in && cnt == PRE) ? START : PREAMBLE;
      end
      START: begin
`ifdef MDIO_SLAVE_CLAUSE45_EN
        state_d = HDR;
        c45_d = mdio.mdio_in == ST_C45[0];
`else
        state_d = mdio.mdio_in == ST_C22[0] ? HDR : ABORT;
`endif
      end
      HDR: begin
        hdr_d = {hdr[10:0], mdio.mdio_in};
        cnt_d = cnt + 6'd1;
        if (cnt == 6'(HDR_BITS - 1)) begin
          cnt_d = '0;
`ifdef MDIO_SLAVE_CLAUSE45_EN
          adr_d = hdr_d[9:5] == phy_address && (!c45 || hdr_d[4:0] == MMD_DEVAD);
          state_d = (!c45 && hdr_d[11:10] == OP_ADDR) ? ABORT : TA0;
`else
          adr_d = hdr_d[9:5] == phy_address;
          state_d = hdr_d[11:10] == OP_ADDR ? ABORT : TA0;
`endif
        end
      end
      TA0: begin
        state_d = (is_rd || mdio.mdio_in) ? TA1 : ABORT;
        oe_d = is_rd && adr;
        out_d = !(is_rd && adr);
        sh_d = rd_data;
      end
      TA1: begin
        state_d = (is_rd || !mdio.mdio_in) ? DATA : ABORT;
        out_d = oe ? sh[15] : 1'b1;
        sh_d = {sh[14:0], mdio.mdio_in};
      end
      DATA: begin
        // one shifter serves both directions: MSB drives the pad, LSB collects write data
        cnt_d = cnt + 6'd1;
        sh_d = {sh[14:0], mdio.mdio_in};
        out_d = oe ? sh[15] : 1'b1;
        if (last) begin
          state_d = PREAMBLE;
          cnt_d = '0;
          oe_d = 1'b0;
          out_d = 1'b1;
          wr_req = adr && hdr[11:10] == OP_WRITE;
`ifdef MDIO_SLAVE_CLAUSE45_EN
          if (c45 && adr && hdr[11:10] == OP_ADDR) mmd_addr_d = wr_val;
          if (c45 && adr && hdr[11:10] == OP_C45_READ_INC) mmd_addr_d = mmd_addr + 16'd1;
`endif
        end
      end
      default: begin
        state_d = PREAMBLE;
        cnt_d = '0;
        oe_d = 1'b0;
        out_d = 1'b1;
      end
    endcase
  end
  mdio_regfile #(.NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)) u_regfile (
    .mdc(mdc),
    .reset(reset),
    .rd_idx(idx),
    .rd_data(rd_data),
    .wr_req(wr_req),
    .wr_idx(idx),
    .wr_val(wr_val),
    .ro_data(ro_data),
    .reg_q(reg_q),
    .wr_strobe(mdio.wr_strobe),
    .wr_addr(mdio.wr_addr),
    .wr_data(mdio.wr_data)
  );
endmodule

// File: doc/mdio_slave_regfile.md
Name: mdio_slave_regfile

Overview:
- Synthesizable, parametrised successor of the MDIO PHY-side slave.
- Clocked by MDC. Decodes Clause 22 frames with enforced preamble and turnaround checking.
- Serves an internal register file of NUM_REGS x 16 bits, with read-only slots sourced from PHY-core status.
- Splits the pad into separate in/out/oe signals for a top-level IO buffer, and signals committed writes to the PHY core.

Parameters:
- NUM_REGS, 32, number of implemented registers (1..32); addresses >= NUM_REGS are unimplemented.
- RO_MASK, 32'h0000_0006, bit i=1 makes register i read-only; its read data comes from ro_data.
- PREAMBLE_LEN, 32, consecutive 1s required before a start bit (1..32).
- MMD_DEVAD, 5'd1, device address answered in Clause 45 frames (only with the optional feature).

Ports:
- mdc  in  1  MDIO clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- phy_address  in  5  strap address matched against PHYAD/PRTAD.
- mdio_in  in  1  pad input.
- mdio_out  out  1  pad output value.
- mdio_oe  out  1  pad output enable.
- ro_data  in  NUM_REGS*16  live values for read-only registers; slice i is register i.
- reg_q  out  NUM_REGS*16  current register-file contents; RO slots read as 0.
- wr_strobe  out  1  one-cycle pulse on a committed write.
- wr_addr  out  5  register index of the committed write.
- wr_data  out  16  data of the committed write.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=PREAMBLE, preamble count=0.
  - mdio_oe=0, mdio_out=1, wr_strobe=0, wr_addr=0, wr_data=0.
  - All RW registers = 16'h0000.
  - Reset mid-frame releases the pad immediately and discards the frame.
- Bit k is sampled at a rising edge. Outputs are registered and change just after that edge, so they are valid for the next bit period.
- PREAMBLE state:
  - mdio_in=1: count increments, saturating at PREAMBLE_LEN.
  - mdio_in=0 with count==PREAMBLE_LEN: go to START.
  - mdio_in=0 with count below PREAMBLE_LEN: clear count and stay.
- START: sample the second ST bit.
  - 1: Clause 22 frame, go to HDR.
  - 0: Clause 45 if enabled, else ABORT.
- HDR: shift 12 bits, OP[1:0], PHYAD[4:0], REGAD[4:0], MSB first. After the 12th bit, go to TA0.
  - addressed = (PHYAD==phy_address).
  - OP 2'b00 in Clause 22 → ABORT.
- TA0:
  - Write: sample must be 1, else ABORT.
  - Read: mdio_oe stays 0. Leaving TA0, if addressed, set mdio_oe=1, mdio_out=0 and load the shift register with read data.
- TA1:
  - Write: sample must be 0, else ABORT.
  - Read (addressed): drive data[15]; the next 15 edges shift the remaining bits out MSB first.
- DATA: 16 bits, bit counter 0..15.
  - Write: shift mdio_in in.
  - Read: the edge sampling the 16th bit period deasserts mdio_oe.
  - Then return to PREAMBLE with count=0.
- Read data selection:
  - Address >= NUM_REGS → 16'h0000.
  - RO_MASK[i] set → ro_data slice i, captured at the TA0 edge.
  - Otherwise → register i.
- Write commit (edge after the last data bit), only when addressed, address < NUM_REGS and RO_MASK[addr]=0:
  - Register updated.
  - wr_strobe=1 for exactly one cycle with wr_addr/wr_data.
  - Other writes are silently dropped with no strobe.
- Unaddressed frames: never drive, never write, but track framing to the end.
- ABORT: mdio_oe=0, count=0, go to PREAMBLE. A fresh preamble is needed.
- Back-to-back frames: a 0 arriving after PREAMBLE_LEN 1s, immediately after DATA, starts a new frame.

Optional Feature:
- Macro MDIO_SLAVE_CLAUSE45_EN.
- Defined: ST=00 frames are decoded. REGAD is DEVAD and must equal MMD_DEVAD, in addition to the PRTAD match. A 16-bit address register (reset 0) is added.
  - OP 00: load the address register from the data field.
  - OP 01: write register[addr].
  - OP 11: read register[addr].
  - OP 10: read, then increment the address register, wrapping 16'hFFFF→0.
  - Register index = address[4:0], with range and RO rules as above.
- Undefined: ST=00 → ABORT, and there is no address register.

Decomposition:
- Package mdio_pkg: state enum (PREAMBLE, START, HDR, TA0, TA1, DATA, ABORT), ST/OP encodings, field-width constants.
- Sub-module mdio_regfile: storage, RO muxing, write qualification and strobe generation.
- Frame FSM stays in the top module.

Test Plan:
- Write: 32x1, 01 01, PHYAD=5 (strap 5), REGAD=3, TA 10, data 16'hA5C3 → wr_strobe one cycle, wr_addr=3, wr_data=A5C3. A following read of reg 3 → oe rises at TA1 with 0, then A5C3 MSB first, then oe drops.
- Read RO reg 2 with ro_data slice 2=16'h0141 → pad carries 0141. Write 16'hFFFF to reg 2 → no strobe and reads still 0141.
- 31 preamble 1s then a frame → ignored, oe never asserts. Write with TA=11 → ABORT, no strobe, and the next valid frame works.
- PHYAD=6 vs strap 5 → no drive, no write. REGAD=31 with NUM_REGS=16: read returns 0000, write is dropped.
- Reset low during DATA of a read → oe=0 immediately. After release, a new read succeeds and registers are 0000.
- With MDIO_SLAVE_CLAUSE45_EN: address frame 16'h0004, then OP 10 read twice → regs 4 then 5. Without the macro, ST=00 → no response.
